// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back (port A) has priority,
// multi-cycle unit results (port B) wait in a small FIFO and age toward a stall request.
module regs_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        mcu_valid,
    output logic        mcu_ready,
    input  logic [4:0]  mcu_rd,
    input  logic [31:0] mcu_data,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data,
    output logic        stall_req,
    output logic [31:0] pend_mask
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AGE_W = $clog2(MAX_WAIT + 1);

    logic [4:0]       r_rd_q   [DEPTH];
    logic [31:0]      r_data_q [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [AGE_W-1:0] r_age;
    logic             r_stall;

    logic             w_full;
    logic             w_empty;
    logic             w_a_write;
    logic             w_push;
    logic             w_pop;
    logic [AGE_W-1:0] w_age_next;
    logic [31:0]      w_pend;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_a_write = wb_valid && (wb_rd != 5'd0);
    // Results for r0 are acknowledged but never occupy a FIFO slot.
    assign w_push    = mcu_valid && !w_full && (mcu_rd != 5'd0);
    assign w_pop     = !w_a_write && !w_empty;

    always_comb begin
        w_age_next = '0;
        if (w_pop || w_empty) begin
            w_age_next = '0;
        end else if (r_age == AGE_W'(MAX_WAIT)) begin
            w_age_next = r_age;
        end else begin
            w_age_next = r_age + AGE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_age    <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_age   <= w_age_next;
            r_stall <= (w_age_next == AGE_W'(MAX_WAIT));
        end
    end

    // Payload storage carries no reset; occupancy is tracked by r_vld.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_q[r_wr_ptr]   <= mcu_rd;
            r_data_q[r_wr_ptr] <= mcu_data;
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) begin
                w_pend[r_rd_q[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        rf_we   = 1'b0;
        rf_rd   = 5'd0;
        rf_data = 32'd0;
        if (reset_n) begin
            if (w_a_write) begin
                rf_we   = 1'b1;
                rf_rd   = wb_rd;
                rf_data = wb_data;
            end else if (!w_empty) begin
                rf_we   = 1'b1;
                rf_rd   = r_rd_q[r_rd_ptr];
                rf_data = r_data_q[r_rd_ptr];
            end
        end
    end

    assign mcu_ready = reset_n && !w_full;
    assign stall_req = r_stall;
    assign pend_mask = w_pend;

endmodule
